mac_frame_sequencer: RTL and testbench
======================================

// Module: mac_frame_sequencer
// PURPOSE
//  Upstream feeder for the pipelined MAC stage. Buffers operand pairs from a valid/ready
//  source and drives the MAC operand inputs one pair per cycle, zeros when idle.
//  Groups pairs into frames of VEC_LEN and returns each frame's dot product, computed as
//  the accumulator difference across the frame, on a valid/ready result port.
//  The MAC never clears, so this block alone defines frame results.
// PARAMETERS
//  DEPTH    4  operand FIFO entries; power of 2, >=2
//  VEC_LEN  4  operand pairs per frame; >=1
//  W_OP     4  operand width; must match MAC in1/in2
//  W_ACC    9  accumulator width; must match MAC out
// PORTS
//  clock      in   1      single clock, rising edge
//  reset_n    in   1      synchronous, active-low reset; MAC reset is tied to ~reset_n
//  op_valid   in   1      operand pair offered
//  op_ready   out  1      FIFO can accept a pair (= !full)
//  op_a       in   W_OP   operand A
//  op_b       in   W_OP   operand B
//  in1        out  W_OP   to MAC in1; registered
//  in2        out  W_OP   to MAC in2; registered
//  mac_out    in   W_ACC  from MAC out (accumulator)
//  res_valid  out  1      frame result held
//  res_ready  in   1      result consumer ready
//  res_data   out  W_ACC  frame dot product, mod 2^W_ACC
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): FIFO empty, op_ready=1 next cycle, in1=in2=0,
//   res_valid=0, res_data=0, pair counter=0, in-flight tags cleared. Mid-frame reset
//   discards the partial frame and any held result. No result is emitted for it.
//  Accept: pair written on an edge with op_valid&&op_ready. op_ready depends only on
//   full, with no pop-while-full pass-through. No bypass: an accept at edge e issues at
//   edge e+1 at the earliest.
//  Issue: on each edge, if the FIFO is non-empty and not stalled, pop into in1/in2 and
//   increment the pair counter (wraps VEC_LEN-1 -> 0). Otherwise load in1=in2=0. A zero
//   product leaves the accumulator unchanged.
//  Stall: the last pair of a frame (counter==VEC_LEN-1) is not issued while res_valid=1
//   or a last-tag is in flight. Other pairs never stall.
//  MAC timing: a pair driven in cycle k is reflected in mac_out in cycle k+2.
//   base  := mac_out sampled in cycle kfirst+1
//   end   := mac_out sampled in cycle klast+2
//   res_data := (end - base) mod 2^W_ACC; res_valid=1 from cycle klast+3
//   VEC_LEN=1: kfirst=klast; use the same rule.
//   Implement with 1-cycle "first" and 2-cycle "last" tag shift registers.
//  Result handshake: res_valid/res_data hold until the edge with res_ready=1, then
//   res_valid=0. A new result never overwrites a held one, which the stall rule ensures.
//  Width: subtraction is W_ACC-bit unsigned and wraps. The result is exact iff the true
//   dot product is <= 2^W_ACC-1.
//  Accumulator wrap during a frame is handled by the modular difference.
// STRUCTURE
//  Package mac_pkg: W_OP, W_ACC, VEC_LEN defaults, and the MAC pipeline latency
//   constant MAC_LAT=2.
//  Sub-module mac_op_fifo: synchronous FIFO, DEPTH x 2*W_OP, push/pop/full/empty,
//   sync active-low reset.
//  Top level: issue register, pair counter, first/last tag pipes, base register,
//   result register.
// TESTING  (bench instantiates this block driving the real MAC)
//  1. Reset, then push (1,2),(3,4),(5,6),(7,8) back-to-back, res_ready=1
//     -> res_data=100, res_valid 1 cycle; in1/in2 return to 0.
//  2. Two frames of (15,15)x4, res_ready=1 -> 900 mod 512 = 388 both times.
//     mac_out wraps; the difference is still 388.
//  3. Hold res_ready=0 after frame 1 of (1,1)x4; push frame 2
//     -> 3 pairs issue, 4th stalls, op_ready drops once FIFO fills.
//     Release -> results 4 then 4, in order, none lost.
//  4. op_valid toggled 1/0 with gaps mid-frame -> zeros inserted.
//     Result still equals the exact dot product, e.g. (2,3),(0,9),(4,4),(1,1) -> 23.
//  5. Assert reset_n=0 after 2 pairs of a frame -> no res_valid.
//     The next full frame (1,1)x4 yields 4.
//  6. VEC_LEN=1 build: push (3,5),(2,2) -> results 15, 4.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared defaults for the MAC operand sequencer slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mac_pkg;
    localparam int DEF_W_OP    = 4;
    localparam int DEF_W_ACC   = 9;
    localparam int DEF_VEC_LEN = 4;
    localparam int DEF_DEPTH   = 4;
    // Cycles from operands on in1/in2 to their product showing on mac_out.
    localparam int MAC_LAT     = 2;
endpackage

// File: rtl/mac_frame_sequencer_if.sv
// Bundles operand input, MAC operand/accumulator and frame result signals.
// Latency: n/a (wires only).
// Backpressure: op_ready/res_ready carried here; slave = sequencer side.
interface mac_frame_sequencer_if
    import mac_pkg::*;
#(
    parameter int W_OP  = DEF_W_OP,
    parameter int W_ACC = DEF_W_ACC
);
    logic             op_valid;
    logic             op_ready;
    logic [W_OP-1:0]  op_a;
    logic [W_OP-1:0]  op_b;
    logic [W_OP-1:0]  in1;
    logic [W_OP-1:0]  in2;
    logic [W_ACC-1:0] mac_out;
    logic             res_valid;
    logic             res_ready;
    logic [W_ACC-1:0] res_data;

    modport master (
        output op_valid, op_a, op_b, mac_out, res_ready,
        input  op_ready, in1, in2, res_valid, res_data
    );

    modport slave (
        input  op_valid, op_a, op_b, mac_out, res_ready,
        output op_ready, in1, in2, res_valid, res_data
    );
endinterface

// File: rtl/mac_op_fifo.sv
// Synchronous operand-pair FIFO, DEPTH entries of W bits.
// Latency: pushed entry visible at pop_dat one cycle after the push edge.
// Backpressure: full blocks push (ignored if full); pop ignored when empty.
// Ports: clock/reset_n, push+push_dat, pop+pop_dat, full, empty.
module mac_op_fifo
    import mac_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = 2 * DEF_W_OP
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_dat = mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push && !full) begin
            mem_d[wr_q[AW-1:0]] = push_dat;
            wr_d = wr_q + (AW+1)'(1);
        end
        if (pop && !empty) begin
            rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end
endmodule

// File: rtl/mac_frame_sequencer.sv
// Feeds MAC operands from a FIFO and returns per-frame dot products (accumulator delta).
// Latency: accept->issue >=1 cycle; result valid 3 cycles after the frame's last issue.
// Backpressure: op_ready = !full; a frame's last pair stalls while a result is held or pending.
// Ports: clock/reset_n plain; bus (slave) carries op_*, in1/in2, mac_out, res_*.
module mac_frame_sequencer
    import mac_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int VEC_LEN = DEF_VEC_LEN,
    parameter int W_OP    = DEF_W_OP,
    parameter int W_ACC   = DEF_W_ACC
) (
    input  logic                 clock,
    input  logic                 reset_n,
    mac_frame_sequencer_if.slave bus
);
    localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(VEC_LEN - 1);

    logic [2*W_OP-1:0] fifo_dat;
    logic              fifo_full, fifo_empty, pop;
    logic              at_last, in_flight, stall;

    logic [W_OP-1:0]    in1_q, in1_d, in2_q, in2_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Tags ride alongside the issued pair, then delay to the MAC output timing.
    logic               first_q, first_d, last_q, last_d;
    logic [MAC_LAT-2:0] first_sr_q, first_sr_d;
    logic [MAC_LAT-1:0] last_sr_q, last_sr_d;
    logic [W_ACC-1:0]   base_q, base_d, res_data_q, res_data_d;
    logic               res_valid_q, res_valid_d;

    mac_op_fifo #(.DEPTH(DEPTH), .W(2*W_OP)) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (bus.op_valid),
        .push_dat ({bus.op_a, bus.op_b}),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign at_last   = (cnt_q == LAST_IDX);
    assign in_flight = last_q || (|last_sr_q);
    // Holding back the last pair guarantees a held result is never overwritten.
    assign stall     = at_last && (res_valid_q || in_flight);
    assign pop       = !fifo_empty && !stall;

    always_comb begin
        in1_d       = '0;
        in2_d       = '0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        cnt_d       = cnt_q;
        first_sr_d  = '0;
        last_sr_d   = '0;
        base_d      = base_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        if (pop) begin
            {in1_d, in2_d} = fifo_dat;
            first_d        = (cnt_q == '0);
            last_d         = at_last;
            cnt_d          = at_last ? '0 : cnt_q + CW'(1);
        end

        first_sr_d[0] = first_q;
        for (int i = 1; i < MAC_LAT - 1; i++) first_sr_d[i] = first_sr_q[i-1];
        last_sr_d[0] = last_q;
        for (int i = 1; i < MAC_LAT; i++) last_sr_d[i] = last_sr_q[i-1];

        // mac_out one cycle after the first issue still excludes the first product.
        if (first_sr_q[MAC_LAT-2]) base_d = bus.mac_out;

        if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;
        // Modular difference absorbs accumulator wrap inside the frame.
        if (last_sr_q[MAC_LAT-1]) begin
            res_valid_d = 1'b1;
            res_data_d  = bus.mac_out - base_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            in1_q       <= '0;
            in2_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            first_sr_q  <= '0;
            last_sr_q   <= '0;
            base_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            last_q      <= last_d;
            first_sr_q  <= first_sr_d;
            last_sr_q   <= last_sr_d;
            base_q      <= base_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign bus.op_ready  = !fifo_full;
    assign bus.in1       = in1_q;
    assign bus.in2       = in2_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
endmodule

// File: tb/tb_mac_frame_sequencer.sv
// Bench for mac_frame_sequencer: two instances (VEC_LEN=4 and VEC_LEN=1) each driving a MAC model.
// Latency: n/a.
// Backpressure: bench toggles res_ready and waits on op_ready.
module tb_mac_frame_sequencer;
    localparam int W_OP  = 4;
    localparam int W_ACC = 9;
    localparam int DEPTH = 4;
    localparam int VL    = 4;
    localparam int MODV  = 1 << W_ACC;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mac_frame_sequencer_if #(.W_OP(W_OP), .W_ACC(W_ACC)) bus0 ();
    mac_frame_sequencer_if #(.W_OP(W_OP), .W_ACC(W_ACC)) bus1 ();

    mac_frame_sequencer #(.DEPTH(DEPTH), .VEC_LEN(VL), .W_OP(W_OP), .W_ACC(W_ACC)) dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    mac_frame_sequencer #(.DEPTH(DEPTH), .VEC_LEN(1), .W_OP(W_OP), .W_ACC(W_ACC)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    // Pipelined MAC: product registered, then accumulated; never cleared except by reset.
    logic [W_ACC-1:0] prod0, prod1;
    always @(posedge clock) begin
        if (!reset_n) begin
            prod0 <= '0; bus0.mac_out <= '0;
            prod1 <= '0; bus1.mac_out <= '0;
        end else begin
            prod0 <= W_ACC'(bus0.in1) * W_ACC'(bus0.in2);
            bus0.mac_out <= bus0.mac_out + prod0;
            prod1 <= W_ACC'(bus1.in1) * W_ACC'(bus1.in2);
            bus1.mac_out <= bus1.mac_out + prod1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: frames are consecutive groups of accepted pairs; result = sum of products mod 2^W_ACC.
    int unsigned exp0_q[$];
    int unsigned exp1_q[$];
    int unsigned part_sum0;
    int          part_cnt0;

    always @(negedge clock) begin
        if (!reset_n) begin
            exp0_q.delete();
            exp1_q.delete();
            part_sum0 = 0;
            part_cnt0 = 0;
        end else begin
            if (bus0.op_valid && bus0.op_ready) begin
                part_sum0 += int'(bus0.op_a) * int'(bus0.op_b);
                part_cnt0++;
                if (part_cnt0 == VL) begin
                    exp0_q.push_back(part_sum0 % MODV);
                    part_sum0 = 0;
                    part_cnt0 = 0;
                end
            end
            if (bus1.op_valid && bus1.op_ready)
                exp1_q.push_back((int'(bus1.op_a) * int'(bus1.op_b)) % MODV);
            if (bus0.res_valid && bus0.res_ready) begin
                if (exp0_q.size() == 0) check_eq("res0_unexpected", 32'(bus0.res_valid), 0);
                else check_eq("res0_data", 32'(bus0.res_data), exp0_q.pop_front());
            end
            if (bus1.res_valid && bus1.res_ready) begin
                if (exp1_q.size() == 0) check_eq("res1_unexpected", 32'(bus1.res_valid), 0);
                else check_eq("res1_data", 32'(bus1.res_data), exp1_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer one pair and return just after the edge that accepts it.
    task automatic push(input int sel, input logic [W_OP-1:0] a, input logic [W_OP-1:0] b);
        int n = 0;
        if (sel == 0) begin bus0.op_valid = 1'b1; bus0.op_a = a; bus0.op_b = b; end
        else          begin bus1.op_valid = 1'b1; bus1.op_a = a; bus1.op_b = b; end
        while (((sel == 0) ? !bus0.op_ready : !bus1.op_ready) && n < 200) begin
            if (n > 4) begin bus0.res_ready = 1'b1; bus1.res_ready = 1'b1; end
            tick();
            n++;
        end
        if (n >= 200) check_eq("push_timeout", n, 0);
        tick();
        bus0.op_valid = 1'b0;
        bus1.op_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus0.res_ready = 1'b1;
        bus1.res_ready = 1'b1;
        while ((exp0_q.size() != 0 || exp1_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        check_eq("drain_pending", exp0_q.size() + exp1_q.size(), 0);
    endtask

    initial begin
        bus0.op_valid = 1'b0; bus0.op_a = '0; bus0.op_b = '0; bus0.res_ready = 1'b1;
        bus1.op_valid = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.res_ready = 1'b1;
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;

        // Reset state
        check_eq("rst_op_ready",  32'(bus0.op_ready), 1);
        check_eq("rst_in1",       32'(bus0.in1), 0);
        check_eq("rst_in2",       32'(bus0.in2), 0);
        check_eq("rst_res_valid", 32'(bus0.res_valid), 0);
        check_eq("rst_res_data",  32'(bus0.res_data), 0);

        // Back-to-back frame with exact timing
        push(0, 1, 2);
        check_eq("no_bypass_in1", 32'(bus0.in1), 0);
        push(0, 3, 4);
        check_eq("issue_in1", 32'(bus0.in1), 1);
        check_eq("issue_in2", 32'(bus0.in2), 2);
        push(0, 5, 6);
        push(0, 7, 8);
        repeat (3) tick();
        check_eq("res_early", 32'(bus0.res_valid), 0);
        tick();
        check_eq("res_on_time", 32'(bus0.res_valid), 1);
        check_eq("res_100",     32'(bus0.res_data), 100);
        tick();
        check_eq("res_one_cycle", 32'(bus0.res_valid), 0);
        check_eq("idle_in1", 32'(bus0.in1), 0);
        check_eq("idle_in2", 32'(bus0.in2), 0);

        // Accumulator wrap across two frames of 15*15
        for (int i = 0; i < 8; i++) push(0, 15, 15);
        drain();

        // Held result stalls the next frame's last pair, FIFO fills
        bus0.res_ready = 1'b0;
        for (int i = 0; i < 11; i++) push(0, 1, 1);
        repeat (12) tick();
        check_eq("stall_full",      32'(bus0.op_ready), 0);
        check_eq("stall_held_vld",  32'(bus0.res_valid), 1);
        check_eq("stall_held_data", 32'(bus0.res_data), 4);
        check_eq("stall_in1_zero",  32'(bus0.in1), 0);
        bus0.res_ready = 1'b1;
        push(0, 1, 1);
        drain();

        // Gapped pushes with zeros in between
        push(0, 2, 3); repeat (2) tick();
        check_eq("gap_zero_in1", 32'(bus0.in1), 0);
        push(0, 0, 9); repeat (2) tick();
        push(0, 4, 4); repeat (2) tick();
        check_eq("gap_zero_in2", 32'(bus0.in2), 0);
        push(0, 1, 1); repeat (2) tick();
        drain();

        // Mid-frame reset discards the partial frame
        push(0, 1, 1);
        push(0, 1, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("post_rst_no_res", 32'(bus0.res_valid), 0);
            tick();
        end
        for (int i = 0; i < 4; i++) push(0, 1, 1);
        drain();

        // Random traffic with random result backpressure
        for (int i = 0; i < 40; i++) begin
            bus0.res_ready = 1'($urandom_range(0, 1));
            push(0, W_OP'($urandom_range(0, 15)), W_OP'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();

        // Single-pair frames
        push(1, 3, 5);
        push(1, 2, 2);
        drain();
        for (int i = 0; i < 12; i++) begin
            bus1.res_ready = 1'($urandom_range(0, 1));
            push(1, W_OP'($urandom_range(0, 15)), W_OP'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
